// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared constants for the fetch unit and the control unit's opcode field.
// Holds instruction width, program depth, NOP encoding, address/length widths and FSM state codes.
package instr_fetch_unit_pkg;
    localparam int IFU_IW    = 8;
    localparam int IFU_DEPTH = 16;
    localparam int IFU_AW    = 4;
    localparam int IFU_LW    = 5;
    localparam logic [IFU_IW-1:0] IFU_NOP = 8'h00;

    typedef logic [IFU_IW-1:0] instr_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: load and fetch handshake bundle between the control unit and the fetch unit.
// slave  (fetch unit): in load_en/load_valid/load_data/fetch_req/fetch_addr,
//                      out load_ready/load_done/prog_len/instr/instr_valid/fetch_err.
// master (control unit / bench): the mirror image.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int IW = IFU_IW
) ();
    logic              load_en;
    logic              load_valid;
    logic [IW-1:0]     load_data;
    logic              load_ready;
    logic              load_done;
    logic [IFU_LW-1:0] prog_len;
    logic              fetch_req;
    logic [IFU_AW-1:0] fetch_addr;
    logic [IW-1:0]     instr;
    logic              instr_valid;
    logic              fetch_err;

    modport slave (
        input  load_en, load_valid, load_data, fetch_req, fetch_addr,
        output load_ready, load_done, prog_len, instr, instr_valid, fetch_err
    );

    modport master (
        output load_en, load_valid, load_data, fetch_req, fetch_addr,
        input  load_ready, load_done, prog_len, instr, instr_valid, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit_prog_mem.sv
// instr_fetch_unit_prog_mem: DEPTH x IW register file, one write port, one synchronous read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), re_i/raddr_i (read request), rdata_o (held until next read).
// Contents are intentionally not reset.
module instr_fetch_unit_prog_mem
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = IFU_DEPTH,
    parameter int IW    = IFU_IW
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IFU_AW-1:0] waddr_i,
    input  logic [IW-1:0]     wdata_i,
    input  logic              re_i,
    input  logic [IFU_AW-1:0] raddr_i,
    output logic [IW-1:0]     rdata_o
);
    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: loads a program into a small memory, then serves single-cycle-latency fetches.
// Ports: clk, rst_n (async, active-low), bus (instr_fetch_unit_if.slave) carrying the load
// handshake (load_en/valid/data/ready/done, prog_len) and the fetch path (fetch_req/addr,
// instr/instr_valid/fetch_err).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int             DEPTH     = IFU_DEPTH,
    parameter int             IW        = IFU_IW,
    parameter logic [IW-1:0]  NOP_INSTR = IFU_NOP
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.slave   bus
);
    localparam logic [IFU_LW-1:0] DEPTH_L = IFU_LW'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [IFU_LW-1:0] wptr_q, wptr_d, prog_len_q, prog_len_d;
    logic              load_done_q, valid_q, fault_q;
    logic              in_load, closing, we, hit;
    logic [IW-1:0]     rdata;

    assign in_load = state_q == ST_LOAD;
    // Ready only while the session is still open, so a word is never offered on the closing cycle.
    assign bus.load_ready = in_load && bus.load_en && (wptr_q < DEPTH_L);
    assign we      = bus.load_ready && bus.load_valid;
    assign closing = in_load && !bus.load_en;
    // A load request in RUN takes priority, so a fetch in the same cycle faults.
    assign hit = (state_q == ST_RUN) && !bus.load_en && ({1'b0, bus.fetch_addr} < prog_len_q);

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        prog_len_d = prog_len_q;
        if (bus.load_en && !in_load) begin
            state_d = ST_LOAD;
            wptr_d  = '0;
        end else if (we) begin
            wptr_d = wptr_q + 1'b1;
        end else if (closing) begin
            prog_len_d = wptr_q;
            state_d    = (wptr_q != '0) ? ST_RUN : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            wptr_q      <= '0;
            prog_len_q  <= '0;
            load_done_q <= 1'b0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            prog_len_q  <= prog_len_d;
            load_done_q <= closing;
            valid_q     <= bus.fetch_req;
            if (bus.fetch_req) fault_q <= !hit;
        end
    end

    instr_fetch_unit_prog_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wptr_q[IFU_AW-1:0]),
        .wdata_i (bus.load_data),
        .re_i    (bus.fetch_req),
        .raddr_i (bus.fetch_addr),
        .rdata_o (rdata)
    );

    // fault_q starts at 1 so the unreset memory output is masked to NOP after reset.
    assign bus.instr       = fault_q ? NOP_INSTR : rdata;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_err   = valid_q && fault_q;
    assign bus.load_done   = load_done_q;
    assign bus.prog_len    = prog_len_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.IW(8)) bus ();

    instr_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_chk(input string tag, input logic [3:0] addr,
                             input logic [7:0] exp_instr, input logic exp_err);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        tick();
        bus.fetch_req = 1'b0;
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(1'b1));
        chk({tag, "_instr"}, 32'(bus.instr), 32'(exp_instr));
        chk({tag, "_err"},   32'(bus.fetch_err), 32'(exp_err));
    endtask

    logic [7:0] prog [4] = '{8'h1A, 8'h2B, 8'h40, 8'hC0};

    initial begin
        bus.load_en = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0;
        tick(); tick();
        chk("rst_ready", 32'(bus.load_ready), 0);
        chk("rst_len",   32'(bus.prog_len), 0);
        chk("rst_instr", 32'(bus.instr), 0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_err",   32'(bus.fetch_err), 0);
        chk("rst_done",  32'(bus.load_done), 0);
        rst_n = 1'b1;
        tick();
        fetch_chk("empty_fetch", 4'd0, 8'h00, 1'b1);
        tick();
        chk("valid_pulse", 32'(bus.instr_valid), 0);
        chk("err_pulse",   32'(bus.fetch_err), 0);

        bus.load_en = 1'b1;
        tick();
        chk("load_ready", 32'(bus.load_ready), 1);
        for (int i = 0; i < 4; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_en    = 1'b0;
        tick();
        chk("l4_done",  32'(bus.load_done), 1);
        chk("l4_len",   32'(bus.prog_len), 4);
        chk("l4_ready", 32'(bus.load_ready), 0);
        tick();
        chk("l4_done_pulse", 32'(bus.load_done), 0);

        fetch_chk("run_a2", 4'd2, 8'h40, 1'b0);
        tick();
        chk("hold_instr", 32'(bus.instr), 32'h40);
        chk("hold_valid", 32'(bus.instr_valid), 0);
        fetch_chk("run_a5", 4'd5, 8'h00, 1'b1);
        fetch_chk("run_a4", 4'd4, 8'h00, 1'b1);

        for (int i = 0; i < 4; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = 4'(i);
            tick();
            chk($sformatf("b2b_valid%0d", i), 32'(bus.instr_valid), 1);
            chk($sformatf("b2b_instr%0d", i), 32'(bus.instr), 32'(prog[i]));
            chk($sformatf("b2b_err%0d", i),   32'(bus.fetch_err), 0);
        end
        bus.fetch_req = 1'b0;

        bus.load_en = 1'b1;
        fetch_chk("load_wins", 4'd0, 8'h00, 1'b1);
        for (int i = 0; i < 18; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(8'h80 + i);
            bus.fetch_req  = (i == 0);
            bus.fetch_addr = 4'd1;
            chk($sformatf("ovf_ready%0d", i), 32'(bus.load_ready), 32'(i < 16));
            tick();
            bus.fetch_req = 1'b0;
            if (i == 0) begin
                chk("ld_fetch_valid", 32'(bus.instr_valid), 1);
                chk("ld_fetch_err",   32'(bus.fetch_err), 1);
                chk("ld_fetch_instr", 32'(bus.instr), 0);
            end
        end
        bus.load_valid = 1'b0;
        bus.load_en    = 1'b0;
        tick();
        chk("l16_done", 32'(bus.load_done), 1);
        chk("l16_len",  32'(bus.prog_len), 16);
        fetch_chk("l16_a0",  4'd0,  8'h80, 1'b0);
        fetch_chk("l16_a15", 4'd15, 8'h8F, 1'b0);

        bus.load_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(8'h11 * (i + 1));
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_en    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_len",   32'(bus.prog_len), 0);
        chk("mid_rst_ready", 32'(bus.load_ready), 0);
        chk("mid_rst_done",  32'(bus.load_done), 0);
        chk("mid_rst_instr", 32'(bus.instr), 0);
        tick();
        chk("mid_rst_nodone", 32'(bus.load_done), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_nodone", 32'(bus.load_done), 0);
        fetch_chk("post_rst_a0", 4'd0, 8'h00, 1'b1);

        bus.load_en = 1'b1;
        tick();
        bus.load_en = 1'b0;
        tick();
        chk("empty_sess_done", 32'(bus.load_done), 1);
        chk("empty_sess_len",  32'(bus.prog_len), 0);
        fetch_chk("empty_sess_a0", 4'd0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
